// File: rtl/prog_loader_pkg.sv
// Shared definitions for the pico-core program loader: FSM encoding,
// buffer geometry, slot timing and a few reference instruction words.
package prog_loader_pkg;

  localparam int PROG_DEPTH  = 16;
  localparam int ADDR_W      = 4;
  localparam int WORD_W      = 16;
  localparam int LEN_W       = ADDR_W + 1;
  localparam int SLOT_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_EXEC = 3'd3,
    ST_CAP  = 3'd4
  } state_t;

  // Reference instruction words for the pico core (low byte keeps bit7 == bit6).
  localparam logic [WORD_W-1:0] INSN_ADDI_R1_R0_5 = 16'h0505;
  localparam logic [WORD_W-1:0] INSN_LI_R1_3      = 16'h0311;
  localparam logic [WORD_W-1:0] INSN_LI_R2_4      = 16'h0412;
  localparam logic [WORD_W-1:0] INSN_ADD_R3_R1_R2 = 16'h2133;

  // Index of the final word for a requested length; lengths past the buffer
  // size are clamped to the whole buffer.
  function automatic logic [ADDR_W-1:0] last_index(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] n;
    n = (len > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : len;
    return ADDR_W'(n - LEN_W'(1));
  endfunction

endpackage

// File: rtl/prog_buf.sv
// Program word store: one synchronous write port, one combinational read port.
module prog_buf
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [PROG_DEPTH];

  // Write port; contents are visible on the read port from the next cycle.
  // NOTE: the array has no reset -- the host always writes a word before it
  // is run, and a reset network on storage only costs routing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_loader.sv
// Drives the pico core's two-byte instruction-load protocol from a local
// program buffer and captures the core's result byte after each instruction.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              start,
  input  logic              loop,
  input  logic              abort,
  input  logic [7:0]        cpu_result,
  output logic              load_en,
  output logic [6:0]        data_lo,
  output logic [7:0]        data_hi,
  output logic              busy,
  output logic              done,
  output logic              enc_err,
  output logic              res_valid,
  output logic [7:0]        res_data,
  output logic [ADDR_W-1:0] res_index
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, last_q, next_idx, rd_addr;
  logic [WORD_W-1:0] rd_data, shadow_q;
  logic              loop_q, abort_q;
  logic              start_ok, run_end;

  prog_buf u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // A zero-length request never leaves IDLE, so it also never pulses done.
  assign start_ok = (state_q == ST_IDLE) && start && (prog_len != '0);
  // Abort raised during CAP still ends the run at this slot boundary.
  assign run_end  = (state_q == ST_CAP) &&
                    (((idx_q == last_q) && !loop_q) || abort_q || abort);
  assign next_idx = (idx_q == last_q) ? '0 : idx_q + ADDR_W'(1);
  // Address the word that the next LO will send.
  assign rd_addr  = (state_q == ST_IDLE) ? '0 : next_idx;
  assign busy     = (state_q != ST_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed LO/HI/EXEC/CAP slot, exits only after CAP.
  // NOTE: state_d gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_EXEC;
      ST_EXEC: state_d = ST_CAP;
      ST_CAP:  state_d = run_end ? ST_IDLE : ST_LO;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin outputs decoded from the state register and shadow word only.
  always_comb begin
    load_en = 1'b0;
    data_lo = '0;
    data_hi = '0;
    case (state_q)
      ST_LO: begin
        load_en = 1'b1;
        data_lo = shadow_q[6:0];
      end
      ST_HI: begin
        load_en = 1'b1;
        data_hi = shadow_q[15:8];
      end
      default: ;
    endcase
  end

  // Run context, in-flight word, abort latch, flags and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      abort_q   <= 1'b0;
      shadow_q  <= '0;
      enc_err   <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
    end else begin
      // Snapshot on entry to LO so later buffer writes cannot tear a slot.
      if (state_d == ST_LO) begin
        shadow_q <= rd_data;
      end

      if (start_ok) begin
        idx_q   <= '0;
        last_q  <= last_index(prog_len);
        loop_q  <= loop;
        enc_err <= 1'b0;
      end else if ((state_q == ST_CAP) && !run_end) begin
        idx_q <= next_idx;
      end

      // The core rebuilds bit7 from bit6; flag words it would misread.
      if ((state_q == ST_LO) && (shadow_q[7] != shadow_q[6])) begin
        enc_err <= 1'b1;
      end

      if (state_q == ST_IDLE) begin
        abort_q <= start_ok && abort;
      end else if (run_end) begin
        abort_q <= 1'b0;
      end else if (abort) begin
        abort_q <= 1'b1;
      end

      done      <= run_end;
      res_valid <= (state_q == ST_CAP);
      if (state_q == ST_CAP) begin
        res_data  <= cpu_result;
        res_index <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: the bench plays the core, supplying each
// result byte, and checks pin activity slot by slot.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic [LEN_W-1:0]  prog_len = '0;
  logic              start = 1'b0;
  logic              loop = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        cpu_result = '0;
  logic              load_en;
  logic [6:0]        data_lo;
  logic [7:0]        data_hi;
  logic              busy;
  logic              done;
  logic              enc_err;
  logic              res_valid;
  logic [7:0]        res_data;
  logic [ADDR_W-1:0] res_index;

  int checks = 0;
  int errors = 0;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .prog_len   (prog_len),
    .start      (start),
    .loop       (loop),
    .abort      (abort),
    .cpu_result (cpu_result),
    .load_en    (load_en),
    .data_lo    (data_lo),
    .data_hi    (data_hi),
    .busy       (busy),
    .done       (done),
    .enc_err    (enc_err),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_index  (res_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle and sample just after the edge; start is a one-cycle pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Called in a LO cycle; walks the slot and returns in the following cycle.
  task automatic run_slot(input logic [ADDR_W-1:0] idx, input logic [15:0] word,
                          input logic [7:0] result, input logic last,
                          input logic abort_hi, input logic wr_hi,
                          input logic [15:0] wr_word);
    check("lo_load_en", 16'(load_en), 16'd1);
    check("lo_data_lo", 16'(data_lo), 16'(word[6:0]));
    check("lo_data_hi", 16'(data_hi), 16'd0);
    check("lo_busy",    16'(busy),    16'd1);
    cpu_result = result;
    tick();
    check("hi_load_en", 16'(load_en), 16'd1);
    check("hi_data_hi", 16'(data_hi), 16'(word[15:8]));
    check("hi_data_lo", 16'(data_lo), 16'd0);
    if (abort_hi) abort = 1'b1;
    if (wr_hi) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = wr_word;
    end
    tick();
    abort = 1'b0;
    wr_en = 1'b0;
    check("exec_load_en", 16'(load_en), 16'd0);
    check("exec_data",    16'({data_hi, data_lo}), 16'd0);
    tick();
    check("cap_load_en",   16'(load_en),   16'd0);
    check("cap_res_valid", 16'(res_valid), 16'd0);
    check("cap_busy",      16'(busy),      16'd1);
    tick();
    check("res_valid", 16'(res_valid), 16'd1);
    check("res_data",  16'(res_data),  16'(result));
    check("res_index", 16'(res_index), 16'(idx));
    check("done",      16'(done),      16'(last));
    check("busy_after_slot", 16'(busy), 16'(!last));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset state
    #23;
    check("rst_load_en",   16'(load_en),   16'd0);
    check("rst_busy",      16'(busy),      16'd0);
    check("rst_done",      16'(done),      16'd0);
    check("rst_res_valid", 16'(res_valid), 16'd0);
    check("rst_enc_err",   16'(enc_err),   16'd0);
    rst = 1'b0;
    tick();

    // Single ADDI: 4-cycle run, result alongside done
    write_word(4'd0, INSN_ADDI_R1_R0_5);
    prog_len = 5'd1;
    start = 1'b1;
    tick();
    run_slot(4'd0, INSN_ADDI_R1_R0_5, 8'h05, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    check("single_done_pulse",  16'(done),      16'd0);
    check("single_valid_pulse", 16'(res_valid), 16'd0);

    // start while busy is ignored: the run still ends after one word
    prog_len = 5'd1;
    start = 1'b1;
    tick();
    prog_len = 5'd3;
    start = 1'b1;
    run_slot(4'd0, INSN_ADDI_R1_R0_5, 8'h05, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    check("busy_start_idle", 16'(busy), 16'd0);

    // prog_len = 0: no activity and no done
    prog_len = 5'd0;
    start = 1'b1;
    tick();
    check("len0_busy",    16'(busy),    16'd0);
    check("len0_load_en", 16'(load_en), 16'd0);
    tick();
    check("len0_done", 16'(done), 16'd0);

    // Three-word program: results 3, 4, 7 four cycles apart
    write_word(4'd0, INSN_LI_R1_3);
    write_word(4'd1, INSN_LI_R2_4);
    write_word(4'd2, INSN_ADD_R3_R1_R2);
    prog_len = 5'd3;
    start = 1'b1;
    tick();
    run_slot(4'd0, INSN_LI_R1_3,      8'd3, 1'b0, 1'b0, 1'b0, 16'h0);
    run_slot(4'd1, INSN_LI_R2_4,      8'd4, 1'b0, 1'b0, 1'b0, 16'h0);
    run_slot(4'd2, INSN_ADD_R3_R1_R2, 8'd7, 1'b1, 1'b0, 1'b0, 16'h0);

    // Loop with abort; rewrite word 0 during its HI (used on the next pass)
    write_word(4'd0, INSN_ADDI_R1_R0_5);
    prog_len = 5'd2;
    loop = 1'b1;
    start = 1'b1;
    tick();
    loop = 1'b0;
    run_slot(4'd0, INSN_ADDI_R1_R0_5, 8'd5, 1'b0, 1'b0, 1'b1, INSN_LI_R1_3);
    run_slot(4'd1, INSN_LI_R2_4,      8'd4, 1'b0, 1'b0, 1'b0, 16'h0);
    run_slot(4'd0, INSN_LI_R1_3,      8'd3, 1'b0, 1'b0, 1'b0, 16'h0);
    run_slot(4'd1, INSN_LI_R2_4,      8'd9, 1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    check("abort_idle", 16'(busy), 16'd0);

    // prog_len above 16 clamps to a 16-word, 64-cycle run
    prog_len = 5'd20;
    start = 1'b1;
    tick();
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("clamp_cycles", 16'(n),    16'(16 * SLOT_CYCLES));
    check("clamp_done",   16'(done), 16'd1);

    // Encoding error: sticky past the run, cleared by the next start
    write_word(4'd0, 16'h0080);
    prog_len = 5'd1;
    start = 1'b1;
    tick();
    check("enc_lo_data_lo", 16'(data_lo), 16'h0000);
    check("enc_lo_flag",    16'(enc_err), 16'd0);
    tick();
    check("enc_hi_flag",    16'(enc_err), 16'd1);
    check("enc_hi_data_hi", 16'(data_hi), 16'h0000);
    tick();
    tick();
    tick();
    check("enc_done",        16'(done),    16'd1);
    check("enc_flag_at_end", 16'(enc_err), 16'd1);
    tick();
    check("enc_flag_sticky", 16'(enc_err), 16'd1);
    write_word(4'd0, INSN_ADDI_R1_R0_5);
    start = 1'b1;
    tick();
    check("enc_cleared", 16'(enc_err), 16'd0);
    run_slot(4'd0, INSN_ADDI_R1_R0_5, 8'h05, 1'b1, 1'b0, 1'b0, 16'h0);

    // Asynchronous reset mid-EXEC clears outputs without a clock edge
    write_word(4'd0, 16'h0080);
    start = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_enc_err", 16'(enc_err), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",      16'(busy),      16'd0);
    check("arst_load_en",   16'(load_en),   16'd0);
    check("arst_data",      16'({data_hi, data_lo}), 16'd0);
    check("arst_enc_err",   16'(enc_err),   16'd0);
    check("arst_res_data",  16'(res_data),  16'd0);
    check("arst_res_index", 16'(res_index), 16'd0);
    check("arst_done",      16'(done),      16'd0);
    check("arst_res_valid", 16'(res_valid), 16'd0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", 16'(busy), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
